// File: rtl/puf_scan_ctrl.sv
// Memory-port arbiter and scan sequencer for the RAM256 DFF-PUF array.
// The host always wins the port; the scan engine reads a window and accumulates signature/weight.
module puf_scan_ctrl #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 14
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             h_en,
  input  logic [3:0]       h_we,
  input  logic [AW-1:0]    h_a,
  input  logic [DW-1:0]    h_di,
  output logic [DW-1:0]    h_do,
  output logic             m_en,
  output logic [3:0]       m_we,
  output logic [AW-1:0]    m_a,
  output logic [DW-1:0]    m_di,
  input  logic [DW-1:0]    m_do,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    first_addr,
  input  logic [AW-1:0]    last_addr,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic [DW-1:0]    signature,
  output logic [CNT_W-1:0] weight
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    last_q, last_d;
  logic             pend_q, pend_d;
  logic [DW-1:0]    sig_q, sig_d;
  logic [CNT_W-1:0] weight_q, weight_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             issue;

  function automatic logic [CNT_W-1:0] popcount(input logic [DW-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    pend_d   = 1'b0;
    sig_d    = sig_q;
    weight_d = weight_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;

    // Read data of last cycle's issue sits on m_do now, whoever owns the port this cycle.
    if (pend_q) begin
      sig_d    = {sig_q[DW-2:0], sig_q[DW-1]} ^ m_do;
      weight_d = weight_q + popcount(m_do);
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (first_addr <= last_addr) begin
            state_d  = StRun;
            ptr_d    = first_addr;
            last_d   = last_addr;
            sig_d    = '0;
            weight_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!h_en) begin
          issue  = 1'b1;
          pend_d = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          // Compare before increment so last = 2**AW-1 never wraps into a false match.
          if (ptr_q == last_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Entered only right after the final issue, so its capture completes this cycle.
        state_d = StIdle;
        done_d  = !abort;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      last_q   <= '0;
      pend_q   <= 1'b0;
      sig_q    <= '0;
      weight_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      sig_q    <= sig_d;
      weight_q <= weight_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    m_en = 1'b0;
    m_we = 4'b0000;
    m_a  = ptr_q;
    m_di = '0;
    if (h_en) begin
      m_en = 1'b1;
      m_we = h_we;
      m_a  = h_a;
      m_di = h_di;
    end else if (issue) begin
      m_en = 1'b1;
    end
  end

  assign h_do      = m_do;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err_range = err_q;
  assign signature = sig_q;
  assign weight    = weight_q;

endmodule

// File: tb/tb_puf_scan_ctrl.sv
// Scoreboard bench for puf_scan_ctrl with a behavioural RAM256 model.
module tb_puf_scan_ctrl;

  logic        clk, rst_n;
  logic        h_en;
  logic [3:0]  h_we;
  logic [7:0]  h_a;
  logic [31:0] h_di, h_do;
  logic        m_en;
  logic [3:0]  m_we;
  logic [7:0]  m_a;
  logic [31:0] m_di, m_do;
  logic        start, abort;
  logic [7:0]  first_addr, last_addr;
  logic        busy, done, err_range;
  logic [31:0] signature;
  logic [13:0] weight;

  puf_scan_ctrl #(.AW(8), .DW(32), .CNT_W(14)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .h_en       (h_en),
    .h_we       (h_we),
    .h_a        (h_a),
    .h_di       (h_di),
    .h_do       (h_do),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_a        (m_a),
    .m_di       (m_di),
    .m_do       (m_do),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .err_range  (err_range),
    .signature  (signature),
    .weight     (weight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM256 model: byte writes, synchronous read valid the following cycle.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    m_do = 32'h0;
  end
  always @(posedge clk) begin
    if (m_en) begin
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) mem[m_a][8*b +: 8] <= m_di[8*b +: 8];
      end
      if (m_we == 4'b0000) m_do <= mem[m_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sig;
    logic [13:0] wt;
    int          at;
  } scan_t;
  typedef struct {
    logic [31:0] data;
    int          at;
  } rd_t;

  scan_t sq[$];
  rd_t   hq[$];
  int    eq[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen or missing at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  scan_t ms;
  rd_t   mr;
  int    me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sq.size() == 0) flag("unexpected_done");
        else begin
          ms = sq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ms.at));
          chk("signature", 64'(signature), 64'(ms.sig));
          chk("weight", 64'(weight), 64'(ms.wt));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (err_range) begin
        if (eq.size() == 0) flag("unexpected_err_range");
        else begin
          me = eq.pop_front();
          chk("err_cycle", 64'(cyc), 64'(me));
          chk("busy_at_err", 64'(busy), 64'd0);
        end
      end
      while (hq.size() > 0 && hq[0].at <= cyc) begin
        mr = hq.pop_front();
        chk("host_read", 64'(h_do), 64'(mr.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [7:0] a, input logic [31:0] d);
    h_en = 1'b1; h_we = 4'hF; h_a = a; h_di = d;
    tick();
    h_en = 1'b0; h_we = 4'h0; h_di = 32'h0;
  endtask

  task automatic hread(input logic [7:0] a, input logic [31:0] exp);
    h_en = 1'b1; h_we = 4'h0; h_a = a;
    hq.push_back('{data: exp, at: cyc + 1});
    tick();
    h_en = 1'b0;
  endtask

  // Issues start this cycle; expected done lands at start cycle + lat.
  task automatic scan(input logic [7:0] f, input logic [7:0] l, input logic [31:0] sig,
                      input logic [13:0] wt, input int lat);
    first_addr = f; last_addr = l; start = 1'b1;
    sq.push_back('{sig: sig, wt: wt, at: cyc + lat});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_results(input int budget);
    for (int i = 0; i < budget && (busy || sq.size() > 0 || hq.size() > 0); i++) tick();
    if (sq.size() > 0 || hq.size() > 0) begin
      flag("timeout_waiting_for_result");
      sq.delete();
      hq.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; h_en = 1'b0; h_we = 4'h0; h_a = 8'h0; h_di = 32'h0;
    start = 1'b0; abort = 1'b0; first_addr = 8'h0; last_addr = 8'h0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_range), 64'd0);
    chk("rst_sig", 64'(signature), 64'd0);
    chk("rst_weight", 64'(weight), 64'd0);
    chk("rst_m_en", 64'(m_en), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full-array scan of all-ones; a start with a bad range while busy must be ignored.
    for (int i = 0; i < 256; i++) hwrite(8'(i), 32'hFFFF_FFFF);
    scan(8'd0, 8'd255, 32'h0, 14'd8192, 258);
    repeat (5) tick();
    first_addr = 8'd9; last_addr = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_results(400);

    // Single-word scan.
    hwrite(8'd5, 32'h0000_000F);
    scan(8'd5, 8'd5, 32'h0000_000F, 14'd4, 3);
    wait_results(20);

    // Words 1,2,4,8: rotate-XOR cancels to zero.
    hwrite(8'd0, 32'h1); hwrite(8'd1, 32'h2); hwrite(8'd2, 32'h4); hwrite(8'd3, 32'h8);
    scan(8'd0, 8'd3, 32'h0, 14'd4, 6);
    wait_results(20);
    // Same with host reads on alternate cycles: issues at +2,+4,+6,+8, done at +10.
    scan(8'd0, 8'd3, 32'h0, 14'd4, 10);
    hread(8'd1, 32'h2); tick();
    hread(8'd3, 32'h8); tick();
    hread(8'd200, 32'hFFFF_FFFF); tick();
    hread(8'd5, 32'hF); tick();
    wait_results(20);

    // Rotation wrap of bit 31: 0x80000001,0x10,0xF0,0x1 -> 0x1AD, weight 8.
    hwrite(8'd0, 32'h8000_0001); hwrite(8'd1, 32'h10); hwrite(8'd2, 32'hF0);
    hwrite(8'd3, 32'h1);
    scan(8'd0, 8'd3, 32'h0000_01AD, 14'd8, 10);
    hread(8'd2, 32'hF0); tick();
    hread(8'd0, 32'h8000_0001); tick();
    hread(8'd3, 32'h1); tick();
    hread(8'd1, 32'h10); tick();
    wait_results(20);

    // Rejected range: error pulse next cycle, results untouched.
    first_addr = 8'd9; last_addr = 8'd3; start = 1'b1;
    eq.push_back(cyc + 1);
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("err_no_busy", 64'(busy), 64'd0);
    chk("err_sig_hold", 64'(signature), 64'h1AD);
    chk("err_weight_hold", 64'(weight), 64'd8);
    chk("err_queue_drained", 64'(eq.size()), 64'd0);

    // Start with abort in idle: abort wins.
    first_addr = 8'd0; last_addr = 8'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    repeat (10) tick();

    // Abort ten cycles into a full scan: no done, then a clean rescan.
    first_addr = 8'd0; last_addr = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("busy_before_abort", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_to_idle", 64'(busy), 64'd0);
    repeat (300) tick();
    for (int i = 0; i < 6; i++) hwrite(8'(i), 32'hFFFF_FFFF);
    scan(8'd0, 8'd255, 32'h0, 14'd8192, 258);
    wait_results(400);

    // Asynchronous reset mid-scan.
    first_addr = 8'd0; last_addr = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("weight_mid_scan", 64'(weight), 64'd608);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err_range), 64'd0);
    chk("arst_sig", 64'(signature), 64'd0);
    chk("arst_weight", 64'(weight), 64'd0);
    chk("arst_m_en_idle", 64'(m_en), 64'd0);
    h_en = 1'b1;
    #1;
    chk("arst_m_en_host", 64'(m_en), 64'd1);
    h_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", 64'(busy), 64'd0);
    chk("leftover_scans", 64'(sq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
